// File: rtl/mips_iter_divider_if.sv
// Divide handshake bundle between the EXE stage (master) and an iterative divider (slave).
// Two valid/ready operand channels in, one valid-only result channel out.
interface mips_iter_divider_if #(
  parameter int WIDTH = 32
);
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;

  modport master (
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_dividend_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    output s_axis_divisor_tdata,
    input  m_axis_dout_tvalid,
    input  m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    input  s_axis_divisor_tdata,
    output m_axis_dout_tvalid,
    output m_axis_dout_tdata
  );
endinterface

// File: rtl/mips_iter_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, for DIV (signed) / DIVU.
// Result {quotient, remainder} is presented for a single cycle WIDTH+1 cycles after acceptance.
//
// state | meaning
// IDLE  | ready for operands; accepts when both tvalid are high together
// CALC  | one restoring step per edge, WIDTH steps total
// DONE  | result valid for exactly this cycle, then back to IDLE
module mips_iter_divider #(
  parameter int SIGNED_MODE = 1,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  mips_iter_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_dvd;
  logic               r_sign_n;
  logic               r_sign_d;
  logic               r_dz;
  logic [2*WIDTH-1:0] r_tdata;

  logic               w_accept;
  logic               w_last;
  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [2*WIDTH-1:0] w_result;

  assign w_accept = (r_state == IDLE) && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;
  assign w_last   = (r_state == CALC) && (r_cnt == LAST_STEP);

  assign w_dvd_neg = (SIGNED_MODE != 0) && bus.s_axis_dividend_tdata[WIDTH-1];
  assign w_dvs_neg = (SIGNED_MODE != 0) && bus.s_axis_divisor_tdata[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
  assign w_dvs_mag = w_dvs_neg ? -bus.s_axis_divisor_tdata  : bus.s_axis_divisor_tdata;

  // Partial remainder always stays below the divisor, so the WIDTH+1-bit shifted value
  // never overflows and the borrow bit of the trial subtraction is the compare result.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Sign flags are only ever set in signed mode, so unsigned results pass straight through.
  assign w_q_fix  = (r_sign_n ^ r_sign_d) ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix  = r_sign_n ? -w_rem_nxt : w_rem_nxt;
  assign w_result = r_dz ? {{WIDTH{1'b1}}, r_dvd} : {w_q_fix, w_r_fix};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CALC;
      CALC:    if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_dvd    <= '0;
      r_sign_n <= 1'b0;
      r_sign_d <= 1'b0;
      r_dz     <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_rem    <= '0;
        r_quo    <= w_dvd_mag;
        r_dvs    <= w_dvs_mag;
        r_dvd    <= bus.s_axis_dividend_tdata;
        r_sign_n <= w_dvd_neg;
        r_sign_d <= w_dvs_neg;
        r_dz     <= (bus.s_axis_divisor_tdata == '0);
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
      if (w_last) begin
        r_tdata <= w_result;
      end
    end
  end

  assign bus.s_axis_dividend_tready = (r_state == IDLE);
  assign bus.s_axis_divisor_tready  = (r_state == IDLE);
  assign bus.m_axis_dout_tvalid     = (r_state == DONE);
  assign bus.m_axis_dout_tdata      = r_tdata;

endmodule

// File: tb/tb_mips_iter_divider.sv
// Bench for mips_iter_divider: one unsigned (index 0) and one signed (index 1) instance,
// directed stimulus with a per-instance queue of expected results and acceptance cycles.
module tb_mips_iter_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_iter_divider_if #(.WIDTH(W)) u_if ();
  mips_iter_divider_if #(.WIDTH(W)) s_if ();

  mips_iter_divider #(.SIGNED_MODE(0), .WIDTH(W)) u_dut_u (.clk(clk), .reset(reset), .bus(u_if.slave));
  mips_iter_divider #(.SIGNED_MODE(1), .WIDTH(W)) u_dut_s (.clk(clk), .reset(reset), .bus(s_if.slave));

  typedef struct {
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];

  logic        prev_v [2];
  logic [63:0] hold   [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sm, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sm) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sq = sa / sb;
    sr = sa % sb;
    return {sq, sr};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q_u.size() : q_s.size();
  endfunction

  function automatic logic mon_v(input int i);
    return (i == 0) ? u_if.m_axis_dout_tvalid : s_if.m_axis_dout_tvalid;
  endfunction

  function automatic logic [63:0] mon_d(input int i);
    return (i == 0) ? u_if.m_axis_dout_tdata : s_if.m_axis_dout_tdata;
  endfunction

  function automatic logic [1:0] rdy(input int i);
    if (i == 0) return {u_if.s_axis_dividend_tready, u_if.s_axis_divisor_tready};
    return {s_if.s_axis_dividend_tready, s_if.s_axis_divisor_tready};
  endfunction

  // Result monitor: pops the scoreboard on every pulse, checks data, latency, pulse width
  // and that tdata holds its value between pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        hold[i]   <= '0;
        prev_v[i] <= 1'b0;
      end else begin
        if (mon_v(i)) begin
          exp_t e;
          check($sformatf("pulse_width dut%0d", i), 64'(prev_v[i]), 64'd0);
          checks++;
          assert (qsize(i) > 0) else begin
            errors++;
            $error("FAIL unexpected_valid dut%0d: observed pulse with %h, expected none", i, mon_d(i));
          end
          if (qsize(i) > 0) begin
            e = (i == 0) ? q_u.pop_front() : q_s.pop_front();
            check($sformatf("result dut%0d", i), mon_d(i), e.data);
            check($sformatf("latency dut%0d", i), 64'(cyc - e.acc), 64'(W + 1));
          end
          hold[i] <= mon_d(i);
        end else begin
          check($sformatf("hold dut%0d", i), mon_d(i), hold[i]);
        end
        prev_v[i] <= mon_v(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic vd, input logic vs, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      u_if.s_axis_dividend_tvalid = vd;
      u_if.s_axis_divisor_tvalid  = vs;
      u_if.s_axis_dividend_tdata  = a;
      u_if.s_axis_divisor_tdata   = b;
    end else begin
      s_if.s_axis_dividend_tvalid = vd;
      s_if.s_axis_divisor_tvalid  = vs;
      s_if.s_axis_dividend_tdata  = a;
      s_if.s_axis_divisor_tdata   = b;
    end
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t e;
    e.data = model(i == 1, a, b);
    e.acc  = acc;
    if (i == 0) q_u.push_back(e);
    else        q_s.push_back(e);
  endtask

  task automatic start(input int i, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    drive(i, 1'b1, 1'b1, a, b);
    if (expect_result) push(i, a, b, cyc);
  endtask

  task automatic release_in(input int i);
    drive(i, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 64'(q_u.size() + q_s.size()), 64'd0);
    tick();
    check("tready_after_done dut0", 64'(rdy(0)), 64'd3);
    check("tready_after_done dut1", 64'(rdy(1)), 64'd3);
  endtask

  task automatic one_op(input int i, input logic [31:0] a, input logic [31:0] b);
    start(i, a, b, 1'b1);
    tick();
    release_in(i);
    check($sformatf("tready_busy dut%0d", i), 64'(rdy(i)), 64'd0);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    release_in(0);
    release_in(1);
    reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_tready dut%0d", i), 64'(rdy(i)), 64'd3);
      check($sformatf("reset_tvalid dut%0d", i), 64'(mon_v(i)), 64'd0);
      check($sformatf("reset_tdata dut%0d", i), mon_d(i), 64'd0);
    end
    reset = 1'b0;
    tick();

    one_op(0, 32'd7, 32'd2);
    one_op(1, 32'hFFFF_FFF9, 32'd2);
    one_op(1, 32'd7, 32'hFFFF_FFFE);
    one_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    one_op(0, 32'hFFFF_FFFF, 32'd1);
    one_op(1, 32'h8765_4321, 32'h0000_1234);
    one_op(0, 32'hF000_0001, 32'h0001_0003);

    start(0, 32'h1234_5678, 32'd0, 1'b1);
    start(1, 32'h1234_5678, 32'd0, 1'b1);
    tick();
    release_in(0);
    release_in(1);
    wait_drain();

    // Dividend alone for three cycles must not be consumed.
    for (int n = 0; n < 3; n++) begin
      drive(1, 1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD);
      check($sformatf("lone_valid_tready %0d", n), 64'(rdy(1)), 64'd3);
      tick();
    end
    check("lone_valid_not_taken", 64'(rdy(1)), 64'd3);
    start(1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    tick();
    release_in(1);
    check("skew_tready_busy", 64'(rdy(1)), 64'd0);
    wait_drain();

    start(0, 32'd123456, 32'd11, 1'b0);
    k = cyc;
    tick();
    release_in(0);
    while (cyc < k + 10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_tready", 64'(rdy(0)), 64'd3);
    check("abort_tvalid", 64'(mon_v(0)), 64'd0);
    check("abort_tdata", mon_d(0), 64'd0);
    repeat (40) tick();
    one_op(0, 32'd100, 32'd7);

    start(0, 32'd50, 32'd5, 1'b1);
    k = cyc;
    tick();
    drive(0, 1'b1, 1'b1, 32'd9, 32'd4);
    push(0, 32'd9, 32'd4, k + W + 2);
    while (cyc < k + W + 2) tick();
    check("b2b_idle_tready", 64'(rdy(0)), 64'd3);
    tick();
    release_in(0);
    check("b2b_second_busy", 64'(rdy(0)), 64'd0);
    wait_drain();

    repeat (50) tick();
    check("final_queue_empty", 64'(q_u.size() + q_s.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_iter_divider.md
Name: mips_iter_divider

Overview:
- Iterative radix-2 restoring divider. It is the responder end of the divide handshake that the EXE stage initiates for DIV/DIVU.
- Accepts dividend and divisor over a pair of valid/ready input channels. Returns {quotient, remainder} on a valid-only output channel after a fixed latency.
- The design instantiates it twice: one with SIGNED_MODE=1 for DIV, one with SIGNED_MODE=0 for DIVU. It replaces the vendor divider IP pin-for-pin.

Parameters:
- SIGNED_MODE, 1: 1 = two's-complement division, 0 = unsigned division.
- WIDTH, 32: operand width. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_axis_dividend_tvalid  input  1  dividend offered
- s_axis_dividend_tready  output  1  divider can accept dividend
- s_axis_dividend_tdata  input  WIDTH  dividend
- s_axis_divisor_tvalid  input  1  divisor offered
- s_axis_divisor_tready  output  1  divider can accept divisor
- s_axis_divisor_tdata  input  WIDTH  divisor
- m_axis_dout_tvalid  output  1  result valid, one-cycle pulse
- m_axis_dout_tdata  output  2*WIDTH  [2W-1:W] = quotient, [W-1:0] = remainder

Behaviour:
- Clocking and reset: single clock domain on clk. Reset is reset, synchronous, active-high.
- Reset values:
  - state = IDLE
  - both tready = 1
  - m_axis_dout_tvalid = 0
  - m_axis_dout_tdata = 0
  - iteration counter = 0
- Reset asserted mid-operation aborts the division at the next edge: no tvalid pulse, tdata cleared to 0.
- States: IDLE, CALC, DONE.
- Both tready outputs are identical and high only in IDLE.
- IDLE:
  - Acceptance requires both tvalid high in the same cycle. A lone tvalid is not consumed and nothing is latched.
  - On the acceptance edge, latch |dividend| and |divisor| (magnitudes only when SIGNED_MODE=1), the two sign bits, and a divisor-zero flag.
  - On the same edge: clear the partial remainder, counter = 0, go to CALC.
- CALC:
  - One restoring step per edge.
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - If rem >= divisor: subtract divisor and set the quotient LSB to 1.
  - rem is WIDTH+1 bits wide internally to avoid overflow.
  - After WIDTH steps (counter reaches WIDTH-1 on the last step edge), go to DONE.
- DONE:
  - m_axis_dout_tvalid = 1 for exactly this one cycle. There is no output tready, so the consumer must sample in this cycle.
  - Next edge returns to IDLE.
- Latency: acceptance edge E0, then tvalid is high in the cycle following edge E(WIDTH). That is WIDTH+1 cycles after the acceptance cycle. For WIDTH=32, tvalid appears 33 cycles after acceptance.
- Throughput: a new operation can be accepted at the earliest one cycle after the DONE cycle (WIDTH+2 cycles per op).
- m_axis_dout_tdata holds its last result until the next DONE or reset.
- Sign fix-up (SIGNED_MODE=1), applied when entering DONE:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - With SIGNED_MODE=0, no fix-up is applied.
- Divide by zero, both modes: quotient = all ones (0xFFFFFFFF), remainder = original dividend bits. Latency is unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Input tdata and tvalid are ignored outside IDLE. Upstream may change or hold them freely while the divider is busy.
- If valids remain high through DONE into IDLE, a second operation is accepted on the first IDLE edge. Upstream must drop tvalid on its handshake edge to avoid a duplicate.

Test Plan:
- Unsigned 7 / 2 (SIGNED_MODE=0): both valids high for 1 cycle → tready drops next cycle; tvalid is a single pulse 33 cycles after acceptance; tdata = {0x00000003, 0x00000001}; tready back high the cycle after.
- Signed 0xFFFFFFF9 (-7) / 2 → {0xFFFFFFFD, 0xFFFFFFFF}. Signed 7 / 0xFFFFFFFE (-2) → {0xFFFFFFFD, 0x00000001}.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}.
  - Unsigned 0xFFFFFFFF / 1 → {0xFFFFFFFF, 0}.
  - Divide by zero with dividend 0x12345678, both modes → {0xFFFFFFFF, 0x12345678}.
- Skewed handshake: dividend_tvalid high for 3 cycles alone, then divisor_tvalid joins → acceptance only on the joint cycle; result latency is measured from the joint cycle.
- Reset at the 10th CALC cycle → next cycle tready = 1, tvalid stays 0, tdata = 0. A fresh 100 / 7 issued afterwards → {14, 2} with full latency.
- Back-to-back: two ops (50 / 5, then 9 / 4) with valids held high across DONE → results {10, 0}, then {2, 1}. Each tvalid is exactly 1 cycle; tdata is stable between pulses.
